// File: rtl/cpu_trace_pkg.sv
// Shared types for the write-back commit tracer: record layout, FSM states,
// and record pack/unpack helpers.
package cpu_trace_pkg;

  localparam int TR_W      = 71;
  localparam int WDATA_LSB = 0;
  localparam int WDATA_W   = 32;
  localparam int PC_LSB    = 32;
  localparam int PC_W      = 32;
  localparam int WDEST_LSB = 64;
  localparam int WDEST_W   = 5;
  localparam int WEN_BIT   = 69;
  localparam int EXC_BIT   = 70;

  // Field order matches the bit layout {exc, wen, wdest, pc, wdata}.
  typedef struct packed {
    logic        exc;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] pc;
    logic [31:0] wdata;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } trace_state_e;

  function automatic logic [TR_W-1:0] rec_pack(input logic exc, input logic wen,
                                               input logic [4:0] wdest,
                                               input logic [31:0] pc,
                                               input logic [31:0] wdata);
    return {exc, wen, wdest, pc, wdata};
  endfunction

  function automatic trace_rec_t rec_unpack(input logic [TR_W-1:0] raw);
    return trace_rec_t'(raw);
  endfunction

endpackage

// File: rtl/wb_commit_trace_if.sv
// Trace record stream: valid/ready handshake carrying one packed record.
interface wb_commit_trace_if;
  import cpu_trace_pkg::*;

  logic            tr_valid;
  logic            tr_ready;
  logic [TR_W-1:0] tr_data;

  modport master (output tr_valid, output tr_data, input tr_ready);
  modport slave  (input tr_valid, input tr_data, output tr_ready);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush; head reads
// zero while empty so the output is clean out of reset.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 71
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage has no reset; validity is tracked solely by cnt_q, so
  // resetting the array would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/wb_commit_trace.sv
// Write-back commit tracer: trigger/length FSM, drop/retire counters and a
// record FIFO streamed to the debug port. Optional commit filter: WB_TRACE_FILTER_EN.
module wb_commit_trace
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int CNT_W         = 16,
  parameter int STALL_ON_FULL = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wb_commit,
  input  logic [31:0]            wb_pc,
  input  logic                   wb_wen,
  input  logic [4:0]             wb_wdest,
  input  logic [31:0]            wb_wdata,
  input  logic                   wb_exc,
  output logic                   wb_stall,
  input  logic                   trig_en,
  input  logic [31:0]            trig_pc,
  input  logic [CNT_W-1:0]       cap_len,
  input  logic                   arm,
  wb_commit_trace_if.master      tr,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       ret_cnt,
  output logic [1:0]             state
);
  localparam bit STALL = (STALL_ON_FULL != 0);

  trace_state_e     state_q, state_d;
  logic [CNT_W-1:0] ret_q, ret_d, drop_q, drop_d;
  logic             candidate, want, room, push, drop, pop, cap_hit;
  logic             full, empty;

`ifdef WB_TRACE_FILTER_EN
  assign candidate = wb_commit & ((wb_wen & (wb_wdest != 5'd0)) | wb_exc);
`else
  assign candidate = wb_commit;
`endif

  // In ARMED only the triggering commit is recorded; it opens the window.
  assign want = candidate & ((state_q == ST_CAPTURE) |
                             ((state_q == ST_ARMED) & trig_en & (wb_pc == trig_pc)));
  assign pop      = tr.tr_valid & tr.tr_ready;
  assign room     = ~full | pop;
  assign push     = want & room & ~arm;
  assign drop     = want & ~room & ~arm & ~STALL;
  assign wb_stall = STALL & full & ~pop;

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    drop_d  = drop_q;
    if (push && ret_q != '1) ret_d  = ret_q + 1'b1;
    if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
    cap_hit = push && (cap_len != '0) && (ret_d == cap_len);
    unique case (state_q)
      ST_ARMED:   if (!trig_en || want) state_d = cap_hit ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE: if (cap_hit) state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_ARMED;
    endcase
    if (arm) begin
      state_d = ST_ARMED;
      ret_d   = '0;
      drop_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_ARMED;
      ret_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      drop_q  <= drop_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .W(TR_W)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (arm),
    .push   (push),
    .pop    (pop),
    .wdata  (rec_pack(wb_exc, wb_wen, wb_wdest, wb_pc, wb_wdata)),
    .rdata  (tr.tr_data),
    .count  (fifo_cnt),
    .full   (full),
    .empty  (empty)
  );

  assign tr.tr_valid = ~empty;
  assign ret_cnt     = ret_q;
  assign drop_cnt    = drop_q;
  assign state       = state_q;

endmodule

// File: tb/tb_wb_commit_trace.sv
// Scoreboard bench for wb_commit_trace: a drop-mode instance checked through an
// expected-record queue, plus a stall-mode instance checked directly.
module tb_wb_commit_trace;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Drop-mode DUT signals
  logic        wb_commit = 0, wb_wen = 0, wb_exc = 0, trig_en = 0, arm = 0;
  logic [31:0] wb_pc = 0, wb_wdata = 0, trig_pc = 0;
  logic [4:0]  wb_wdest = 0;
  logic [CNT_W-1:0] cap_len = 0;
  logic        wb_stall;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic [CNT_W-1:0] drop_cnt, ret_cnt;
  logic [1:0]  state;
  wb_commit_trace_if tr_if ();

  // Stall-mode DUT signals
  logic        s_commit = 0;
  logic [31:0] s_pc = 0;
  logic        s_stall;
  logic [$clog2(DEPTH):0] s_fifo_cnt;
  logic [CNT_W-1:0] s_drop_cnt, s_ret_cnt;
  logic [1:0]  s_state;
  wb_commit_trace_if s_if ();

  wb_commit_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STALL_ON_FULL(0)) u_dut (
    .clk(clk), .resetn(resetn), .wb_commit(wb_commit), .wb_pc(wb_pc), .wb_wen(wb_wen),
    .wb_wdest(wb_wdest), .wb_wdata(wb_wdata), .wb_exc(wb_exc), .wb_stall(wb_stall),
    .trig_en(trig_en), .trig_pc(trig_pc), .cap_len(cap_len), .arm(arm), .tr(tr_if),
    .fifo_cnt(fifo_cnt), .drop_cnt(drop_cnt), .ret_cnt(ret_cnt), .state(state)
  );

  wb_commit_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STALL_ON_FULL(1)) u_stall (
    .clk(clk), .resetn(resetn), .wb_commit(s_commit), .wb_pc(s_pc), .wb_wen(1'b1),
    .wb_wdest(5'd3), .wb_wdata(~s_pc), .wb_exc(1'b0), .wb_stall(s_stall),
    .trig_en(1'b0), .trig_pc(32'h0), .cap_len('0), .arm(1'b0), .tr(s_if),
    .fifo_cnt(s_fifo_cnt), .drop_cnt(s_drop_cnt), .ret_cnt(s_ret_cnt), .state(s_state)
  );

  logic [70:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [70:0] mk_rec(input logic exc, input logic wen, input logic [4:0] wd,
                                         input logic [31:0] pc, input logic [31:0] wdata);
    return {exc, wen, wd, pc, wdata};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle commit; the expected record is queued only when it should be captured.
  task automatic commit(input logic [31:0] pc, input logic wen, input logic [4:0] wd,
                        input logic exc, input bit expect_push);
    wb_commit = 1; wb_pc = pc; wb_wen = wen; wb_wdest = wd; wb_wdata = ~pc; wb_exc = exc;
    if (expect_push) exp_q.push_back(mk_rec(exc, wen, wd, pc, ~pc));
    step();
    wb_commit = 0;
  endtask

  task automatic pulse_arm();
    arm = 1;
    step();
    arm = 0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    tr_if.tr_ready = 1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: every accepted head record is compared against the queue front.
  always @(negedge clk) begin
    if (resetn && tr_if.tr_valid && tr_if.tr_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h expected no record", tr_if.tr_data);
      end else begin
        check("sb_record", 128'(tr_if.tr_data), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tr_if.tr_ready = 1;
    s_if.tr_ready  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tr_valid", 128'(tr_if.tr_valid), 128'd0);
    check("rst_tr_data", 128'(tr_if.tr_data), 128'd0);
    check("rst_fifo_cnt", 128'(fifo_cnt), 128'd0);
    check("rst_counters", 128'({drop_cnt, ret_cnt}), 128'd0);
    check("rst_state", 128'(state), 128'd0);
    check("rst_stall", 128'({wb_stall, s_stall}), 128'd0);
    resetn = 1;

    // 1: free-running capture, one-cycle latency, in-order records
    step();
    check("t1_state_capture", 128'(state), 128'd1);
    check("t1_valid_before", 128'(tr_if.tr_valid), 128'd0);
    commit(32'h00, 1, 5'd3, 0, 1);
    check("t1_valid_after", 128'(tr_if.tr_valid), 128'd1);
    commit(32'h04, 1, 5'd3, 0, 1);
    commit(32'h08, 1, 5'd3, 0, 1);
    drain(10);
    check("t1_ret_cnt", 128'(ret_cnt), 128'd3);
    check("t1_drop_cnt", 128'(drop_cnt), 128'd0);
    check("t1_fifo_cnt", 128'(fifo_cnt), 128'd0);

    // 2: PC trigger at 0x10
    trig_en = 1; trig_pc = 32'h10;
    pulse_arm();
    check("t2_state_armed", 128'(state), 128'd0);
    for (int i = 0; i < 8; i++) commit(32'(i * 4), 1, 5'd3, 0, (i >= 4));
    drain(10);
    check("t2_ret_cnt", 128'(ret_cnt), 128'd4);
    check("t2_state", 128'(state), 128'd1);

    // 3: capture length 2
    trig_en = 0; cap_len = 2;
    pulse_arm();
    step();
    for (int i = 0; i < 5; i++) commit(32'h100 + 32'(i * 4), 1, 5'd3, 0, (i < 2));
    drain(10);
    check("t3_state_done", 128'(state), 128'd2);
    check("t3_ret_cnt", 128'(ret_cnt), 128'd2);

    // 4: overflow in drop mode, then drain in order
    cap_len = 0;
    tr_if.tr_ready = 0;
    pulse_arm();
    step();
    for (int i = 0; i < 20; i++) commit(32'h200 + 32'(i * 4), 1, 5'd3, 0, (i < 16));
    check("t4_fifo_full", 128'(fifo_cnt), 128'd16);
    check("t4_drop_cnt", 128'(drop_cnt), 128'd4);
    check("t4_ret_cnt", 128'(ret_cnt), 128'd16);
    check("t4_head_held", 128'(tr_if.tr_data), 128'(mk_rec(0, 1, 5'd3, 32'h200, ~32'h200)));
    drain(40);
    check("t4_fifo_empty", 128'(fifo_cnt), 128'd0);

    // 5: stall mode, full FIFO
    for (int i = 0; i < 16; i++) begin
      s_commit = 1; s_pc = 32'(i * 4);
      step();
    end
    s_commit = 0;
    check("t5_full", 128'(s_fifo_cnt), 128'd16);
    check("t5_stall_full", 128'(s_stall), 128'd1);
    s_if.tr_ready = 1; s_commit = 1; s_pc = 32'h40;
    #1;
    check("t5_stall_pop", 128'(s_stall), 128'd0);
    step();
    check("t5_cnt_steady", 128'(s_fifo_cnt), 128'd16);
    check("t5_ret_cnt", 128'(s_ret_cnt), 128'd17);
    check("t5_head_next", 128'(s_if.tr_data[63:32]), 128'h4);
    s_if.tr_ready = 0;
    #1;
    check("t5_stall_noready", 128'(s_stall), 128'd1);
    step();
    s_commit = 0;
    check("t5_ret_held", 128'(s_ret_cnt), 128'd17);
    check("t5_no_drop", 128'(s_drop_cnt), 128'd0);

    // 6: commit filter, then arm flush with records pending
    tr_if.tr_ready = 0;
    pulse_arm();
    step();
`ifdef WB_TRACE_FILTER_EN
    commit(32'h300, 1, 5'd0, 0, 0);
    commit(32'h304, 0, 5'd3, 0, 0);
    commit(32'h308, 0, 5'd0, 1, 1);
    commit(32'h30C, 1, 5'd7, 0, 1);
    check("t6_ret_cnt", 128'(ret_cnt), 128'd2);
`else
    commit(32'h300, 1, 5'd0, 0, 1);
    commit(32'h304, 0, 5'd3, 0, 1);
    commit(32'h308, 0, 5'd0, 1, 1);
    commit(32'h30C, 1, 5'd7, 0, 1);
    check("t6_ret_cnt", 128'(ret_cnt), 128'd4);
`endif
    drain(20);
    tr_if.tr_ready = 0;
    commit(32'h310, 1, 5'd2, 0, 0);
    commit(32'h314, 1, 5'd2, 0, 0);
    check("t6_pending", 128'(fifo_cnt), 128'd2);
    pulse_arm();
    check("t6_flush_cnt", 128'(fifo_cnt), 128'd0);
    check("t6_flush_state", 128'(state), 128'd0);
    check("t6_flush_ret", 128'(ret_cnt), 128'd0);
    check("t6_flush_valid", 128'(tr_if.tr_valid), 128'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_commit_trace.md
Name: wb_commit_trace

Overview:
- Downstream consumer of the pipeline CPU's write-back stage.
- Captures one record per retired instruction (PC, register write, exception flag) into a FIFO.
- Streams records out over a valid/ready port to the display/debug logic.
- Optional PC trigger windows the capture; on full, either drops records (counting them) or back-pressures WB.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..256
CNT_W, 16, width of drop/retire counters
STALL_ON_FULL, 0, 1 = assert wb_stall when full; 0 = drop new record and count it

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
wb_commit  in  1  one instruction retires this cycle (WB_valid & WB_over)
wb_pc  in  32  retiring PC
wb_wen  in  1  regfile write enable
wb_wdest  in  5  destination register
wb_wdata  in  32  write data
wb_exc  in  1  retiring instruction is syscall/eret (cancel source)
wb_stall  out  1  back-pressure to WB_over; constant 0 when STALL_ON_FULL=0
trig_en  in  1  1 = wait for trig_pc before capturing
trig_pc  in  32  trigger PC
cap_len  in  CNT_W  records to capture after trigger; 0 = unlimited
arm  in  1  pulse: flush FIFO, clear counters, re-enter ARMED
tr_valid  out  1  head record valid
tr_ready  in  1  consumer accepts head
tr_data  out  71  {exc, wen, wdest[4:0], pc[31:0], wdata[31:0]}
fifo_cnt  out  log2(DEPTH)+1  occupancy
drop_cnt  out  CNT_W  records lost to full FIFO, saturating
ret_cnt  out  CNT_W  records pushed, saturating
state  out  2  FSM state

Behaviour:
- Reset: FIFO empty, tr_valid=0, tr_data=0, wb_stall=0, all counters 0, fifo_cnt=0, state=ARMED.
- FSM encoding: ARMED=0, CAPTURE=1, DONE=2.
- ARMED:
  - trig_en=0 -> CAPTURE on the next clk.
  - trig_en=1 -> go to CAPTURE on the first wb_commit with wb_pc==trig_pc. That triggering record is itself pushed.
- CAPTURE: every wb_commit is a push candidate.
  - If cap_len!=0 and ret_cnt reaches cap_len on a push -> DONE.
- DONE: no pushes; FIFO keeps draining.
- arm pulse (any state): synchronous flush; counters cleared; state=ARMED. arm has priority over a same-cycle push and pop.
- Push: entry written at wr_ptr, ret_cnt++.
- Pop: tr_valid & tr_ready; head advances.
- Latency: a record pushed in cycle N gives tr_valid=1 in cycle N+1. There is no same-cycle bypass.
- tr_data is driven from the head entry and held stable while tr_valid & ~tr_ready.
- Full with push candidate, STALL_ON_FULL=0:
  - Push accepted if a pop occurs the same cycle.
  - Otherwise the record is dropped and drop_cnt++ (saturates at all-ones).
- STALL_ON_FULL=1:
  - wb_stall = full & ~(tr_valid & tr_ready), combinational.
  - A commit is only counted while wb_stall=0; the CPU holds the record until then.
- Empty: simultaneous push+pop is impossible because tr_valid=0; the push proceeds.
- Pointers are log2(DEPTH) bits wrapping modulo DEPTH. fifo_cnt = +1 on push-only, -1 on pop-only, unchanged on push&pop.
- Reset asserted mid-stream discards everything asynchronously. There is no partial record.

Optional Feature:
- Macro: WB_TRACE_FILTER_EN.
- Defined: a commit is a push candidate only if (wb_wen & wb_wdest!=0) | wb_exc.
  - Filtered commits advance neither ret_cnt nor the trigger match; trig_pc must hit a recorded instruction.
- Undefined: every commit is a candidate.

Decomposition:
- Shared package cpu_trace_pkg holds:
  - record field offsets and widths (TR_W=71);
  - FSM state constants;
  - record pack/unpack functions.
- One natural sub-module: trace_fifo (parameterised DEPTH/width synchronous FIFO with count, full, empty). wb_commit_trace wraps it with the FSM, filter and counters.

Test Plan:
1. Reset, trig_en=0, 3 commits (pc 0x00,0x04,0x08; tr_ready=1) -> tr_valid 1 cycle after each; tr_data.pc in order; ret_cnt=3; drop_cnt=0.
2. trig_en=1, trig_pc=0x10, commits pc 0x00..0x1C -> first record pc 0x10; 4 records captured; state=CAPTURE.
3. cap_len=2, trig_en=0, 5 commits -> exactly 2 records; state=DONE; ret_cnt=2.
4. DEPTH=16, STALL_ON_FULL=0, tr_ready=0, 20 commits -> fifo_cnt=16; drop_cnt=4; then 16 pops -> records 0..15 in order.
5. STALL_ON_FULL=1, full, tr_ready=1 with commit in the same cycle -> wb_stall=0; push+pop; fifo_cnt stays 16. With tr_ready=0 -> wb_stall=1.
6. WB_TRACE_FILTER_EN defined, commits with wdest=0, wen=0, and one with wb_exc=1 -> only the exc record and the wdest!=0 records are emitted; arm pulse -> fifo_cnt=0, state=ARMED.
